// File: rtl/alu_seq_if.sv
// Operand/result bundle between the register file, alu_seq and the writeback stage.
// The master drives the request; the slave (the ALU) returns registered result and flags.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             v;
    logic             c;
    logic             z;
    logic             n;

    modport master (
        output start, op, a, b,
        input  busy, done, result, v, c, z, n
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, v, c, z, n
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake; single-cycle ops complete at the accept edge,
// MUL runs a WIDTH-cycle shift-add iteration and ignores start while busy.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_ASR = 4'b1101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Single-cycle datapath; returns {v, c, r}. Shifts carry one guard bit so the
    // last bit shifted out falls into c, and a zero shift leaves c clear.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             c_prev
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic             v;
        logic             c;
        logic [SHW-1:0]   s;
        s   = b[SHW-1:0];
        sum = {(WIDTH+1){1'b0}};
        r   = {WIDTH{1'b0}};
        v   = 1'b0;
        c   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, a} + {1'b0, b} +
                      ((op == OP_ADC) ? {{WIDTH{1'b0}}, c_prev} : {(WIDTH+1){1'b0}});
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: {c, r} = {1'b0, a} << s;
            OP_SHR: {r, c} = {a, 1'b0} >> s;
            OP_ASR: {r, c} = $signed({a, 1'b0}) >>> s;
            default: begin
                r = {WIDTH{1'b0}};
                c = 1'b0;
            end
        endcase
        return {v, c, r};
    endfunction

    state_t             state_r, state_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [WIDTH-1:0]   result_r, result_s;
    logic               v_r, v_s, c_r, c_s, z_r, z_s, n_r, n_s;
    logic [2*WIDTH-1:0] acc_r, acc_s;
    logic [2*WIDTH-1:0] a_sh_r, a_sh_s;
    logic [WIDTH-1:0]   b_sh_r, b_sh_s;
    logic [SHW-1:0]     cnt_r, cnt_s;
    logic [WIDTH+1:0]   eval_s;
    logic [2*WIDTH-1:0] prod_s;

    // Next-state and next-output logic for the IDLE/MUL controller.
    always_comb begin
        state_s  = state_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        result_s = result_r;
        v_s      = v_r;
        c_s      = c_r;
        z_s      = z_r;
        n_s      = n_r;
        acc_s    = acc_r;
        a_sh_s   = a_sh_r;
        b_sh_s   = b_sh_r;
        cnt_s    = cnt_r;
        eval_s   = alu_eval(bus.op, bus.a, bus.b, c_r);
        prod_s   = acc_r + (b_sh_r[0] ? a_sh_r : {(2*WIDTH){1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
                        state_s = ST_MUL;
                        busy_s  = 1'b1;
                        acc_s   = {(2*WIDTH){1'b0}};
                        a_sh_s  = {{WIDTH{1'b0}}, bus.a};
                        b_sh_s  = bus.b;
                        cnt_s   = {SHW{1'b0}};
                    end else begin
                        done_s   = 1'b1;
                        result_s = eval_s[WIDTH-1:0];
                        c_s      = eval_s[WIDTH];
                        v_s      = eval_s[WIDTH+1];
                        z_s      = (eval_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        n_s      = eval_s[WIDTH-1];
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_s  = prod_s;
                a_sh_s = a_sh_r << 1;
                b_sh_s = b_sh_r >> 1;
                cnt_s  = cnt_r + {{(SHW-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_LAST) begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                    done_s   = 1'b1;
                    result_s = prod_s[WIDTH-1:0];
                    c_s      = |prod_s[2*WIDTH-1:WIDTH];
                    v_s      = |prod_s[2*WIDTH-1:WIDTH];
                    z_s      = (prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    n_s      = prod_s[WIDTH-1];
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset also aborts any MUL in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            v_r      <= 1'b0;
            c_r      <= 1'b0;
            z_r      <= 1'b0;
            n_r      <= 1'b0;
            acc_r    <= {(2*WIDTH){1'b0}};
            a_sh_r   <= {(2*WIDTH){1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            cnt_r    <= {SHW{1'b0}};
        end else begin
            state_r  <= state_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            result_r <= result_s;
            v_r      <= v_s;
            c_r      <= c_s;
            z_r      <= z_s;
            n_r      <= n_s;
            acc_r    <= acc_s;
            a_sh_r   <= a_sh_s;
            b_sh_r   <= b_sh_s;
            cnt_r    <= cnt_s;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.v      = v_r;
    assign bus.c      = c_r;
    assign bus.z      = z_r;
    assign bus.n      = n_r;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed ops push expected results,
// a negedge monitor pops one entry per done pulse.
module tb_alu_seq;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_ASR = 4'b1101;

    typedef struct {
        int         id;
        logic [7:0] r;
        logic [3:0] vczn;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    alu_seq_if #(.WIDTH(8)) bus ();
    alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Push the expected response and hold start for exactly one accept edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [3:0] vczn);
        exp_t e;
        e.id = txn;
        e.r = er;
        e.vczn = vczn;
        txn++;
        sb_q.push_back(e);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic issue_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] er,
                             input logic [3:0] vczn, input bit inject);
        int edges;
        bit busy_ok;
        edges = 0;
        busy_ok = 1'b1;
        issue(OP_MUL, a, b, er, vczn);
        while (!bus.done && edges < 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (inject && edges == 2) begin
                bus.start = 1'b1;
                bus.op = OP_ADD;
                bus.a = 8'h01;
                bus.b = 8'h01;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        bus.start = 1'b0;
        check("mul_latency", edges, 8);
        check("mul_busy_held", {31'd0, busy_ok}, 32'd1);
        check("mul_busy_clear", {31'd0, bus.busy}, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.done || bus.busy) begin
            checks++;
            if (bus.done && bus.busy) begin
                errors++;
                $display("FAIL busy_done_overlap: got busy=1 done=1 required not both");
            end
        end
        if (bus.done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 r=%h required no done", bus.result);
            end else begin
                mon_e = sb_q.pop_front();
                if ({bus.result, bus.v, bus.c, bus.z, bus.n} !== {mon_e.r, mon_e.vczn}) begin
                    errors++;
                    $display("FAIL txn%0d: got r=%h vczn=%b required r=%h vczn=%b", mon_e.id,
                             bus.result, {bus.v, bus.c, bus.z, bus.n}, mon_e.r, mon_e.vczn);
                end
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 4'h0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, bus.busy, bus.done, bus.result, bus.v, bus.c, bus.z, bus.n}, 32'd0);
        rst = 1'b0;

        // Back-to-back single-cycle ops; expected {v,c,z,n} hand-computed.
        issue(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001);
        issue(OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b0101);
        issue(OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1000);
        issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0110);
        issue(OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000);
        issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        issue(OP_OR,  8'h0F, 8'h80, 8'h8F, 4'b0001);
        issue(OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0010);
        issue(OP_NOT, 8'h0F, 8'h55, 8'hF0, 4'b0001);
        issue(OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0100);
        issue(OP_SHR, 8'h01, 8'h01, 8'h00, 4'b0110);
        issue(OP_ASR, 8'h80, 8'h03, 8'hF0, 4'b0001);
        issue(OP_SHL, 8'hA5, 8'h08, 8'hA5, 4'b0001);
        issue(OP_ASR, 8'hC3, 8'h02, 8'hF0, 4'b0101);
        issue(4'hF,   8'hFF, 8'hFF, 8'h00, 4'b0010);
        issue(4'h0,   8'h12, 8'h34, 8'h00, 4'b0010);

        issue_mul(8'h0F, 8'h03, 8'h2D, 4'b0000, 1'b0);
        issue_mul(8'hFF, 8'hFF, 8'h01, 4'b1100, 1'b0);
        issue_mul(8'h10, 8'h10, 8'h00, 4'b1110, 1'b1);
        // Accepted in the same cycle the MUL done is high; c_prev=1 from the MUL.
        issue(OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000);
        issue(OP_ADD, 8'hFF, 8'hFF, 8'hFE, 4'b0101);

        // MUL aborted by reset in its 4th cycle: no entry is pushed, so any done fails.
        bus.start = 1'b1;
        bus.op = OP_MUL;
        bus.a = 8'h55;
        bus.b = 8'h03;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("abort_mul_busy", {31'd0, bus.busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midmul_reset_outputs", {19'd0, bus.busy, bus.done, bus.result, bus.v, bus.c, bus.z, bus.n}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_busy", {31'd0, bus.busy}, 32'd0);

        issue(OP_ADC, 8'h00, 8'h00, 8'h00, 4'b0010);
        issue(OP_ADD, 8'h02, 8'h03, 8'h05, 4'b0000);

        w = 0;
        while (sb_q.size() != 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU and successor to the 4-bit combinational ALU. It adds configurable data width, registered result and flags, and a start/done handshake. It also adds ops the previous block lacked: add-with-carry, variable shifts, arithmetic shift and an iterative multi-cycle multiply. It sits between the datapath register file and the accumulator/writeback stage and accepts one operation at a time.

## Interface
- WIDTH, 8, data width; power of two, 4..32
- SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted on a rising edge when busy=0
- op  input  4  operation code, sampled at accept
- a  input  WIDTH  operand A, sampled at accept
- b  input  WIDTH  operand B (shift amount = b[SHW-1:0]), sampled at accept
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse: result/flags updated this cycle
- result  output  WIDTH  registered result, held until next done
- v, c, z, n  output  1 each  registered overflow, carry/borrow, zero, negative flags

## Operation
- Op codes; all arithmetic is modulo 2^WIDTH, r = result:
  - 0001 ADD: r=a+b. c = carry out. v = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - 0011 ADC: r=a+b+c_prev, with c_prev being the registered c. Flags as ADD.
  - 0010 SUB: r=a-b. c = borrow (a<b unsigned). v = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - 0101 AND, 0110 OR, 0100 XOR, 0111 NOT a: v=c=0.
  - 1000 SHL, 1100 SHR (logical), 1101 ASR, each by amount s=b[SHW-1:0]:
    - c = last bit shifted out.
    - s=0: r=a, c=0.
    - v=0.
  - 1001 MUL: unsigned shift-add, one partial product per cycle. r = low WIDTH bits of a*b. c=v=1 iff the high WIDTH bits are nonzero.
  - Any other code: r=0, v=c=0 (so z=1).
- z = (r==0). n = r[WIDTH-1]. Every op updates all four flags at its done.
- State machine:
  - IDLE: start=1 with op≠MUL → compute and register at the same edge, pulse done, stay IDLE. start=1 with op=MUL → latch a, b, clear the accumulator, iteration count=0, go to MUL.
  - MUL: each edge adds (b_shift[0] ? a_shift : 0) to the 2·WIDTH accumulator, shifts, and increments the count. After the WIDTH-th iteration: register result/flags, pulse done, return to IDLE.
- start while busy=1 is ignored (not queued). a/b/op may change freely during MUL.
- Reset (rst=1 at any edge, including mid-MUL):
  - state=IDLE; busy=0, done=0, result=0, v=c=z=n=0.
  - The aborted MUL never produces done.
  - ADC after reset uses c_prev=0.

## Timing
- Single-cycle ops: start accepted at edge E0; result, flags and done=1 are visible after E0; done drops after E1 unless a new op is accepted at E1. Back-to-back accepts every cycle are allowed, with done high continuously.
- MUL: accepted at E0; busy=1 after E0 through E(WIDTH-1). After E(WIDTH): busy=0, done=1, result valid. Latency = WIDTH cycles.
- A new start may be accepted in the same cycle done is high (busy=0), with no bubble.
- busy and done are never high together.
- Outputs are fully registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0x7F, b=0x01 → after one edge: result=0x80, v=1, c=0, n=1, z=0, done pulses once.
- SUB a=0x00, b=0x01 → result=0xFF, c=1, v=0, n=1. SUB 0x80−0x01 → result=0x7F, v=1.
- ADD 0xFF+0x01 → result=0x00, c=1, z=1; next cycle ADC a=0x00, b=0x00 → result=0x01, c=0. After reset, ADC 0x00+0x00 → result=0x00.
- MUL a=0x0F, b=0x03 → busy for 8 cycles, then result=0x2D, c=v=0, done exactly 8 edges after accept. MUL 0x10×0x10 → result=0x00, c=v=1, z=1. A start pulse (ADD) issued mid-MUL is ignored.
- SHL 0x81 by 1 → 0x02, c=1. SHR 0x01 by 1 → 0x00, c=1, z=1. ASR 0x80 by 3 → 0xF0, n=1, c=0. Any shift by 0 → r=a, c=0. Op 0xF → result 0x00, z=1.
- Assert rst at the 4th MUL cycle → next edge busy=0, all outputs 0, no done thereafter. A subsequent ADD 0x02+0x03 → 0x05 after one edge.
